// File: rtl/mult_div_sequencer.sv
// Sequential signed multiplier (radix-2 Booth) and restoring divider sharing one datapath.
// Optional macro MULTDIV_DIVZERO_EN: divide by zero finishes in one cycle and raises divZero.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multOp,
    input  logic             divOp,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             hiLoWrite,
    output logic             divZero,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return {WIDTH{1'b0}} - x;
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;      // Booth accumulator / partial remainder
    logic [WIDTH-1:0] qr_q, qr_d;        // multiplier / quotient shift register
    logic [WIDTH-1:0] m_q, m_d;          // multiplicand / divisor magnitude
    logic             q1_q, q1_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hilo_q, hilo_d;
    logic             dz_d;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // Next-state, datapath iteration and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        m_d       = m_q;
        q1_d      = q1_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = 1'b0;
        booth_sum = acc_q;
        rem_sh    = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, m_q};
        case (state_q)
            S_IDLE: begin
                if (divOp) begin
                    cnt_d   = {CW{1'b0}};
                    acc_d   = {(WIDTH+1){1'b0}};
                    qr_d    = abs_w(opA);
                    m_d     = abs_w(opB);
                    q1_d    = 1'b0;
                    // A zero divisor keeps the all-ones quotient unsigned.
                    negq_d  = (opA[WIDTH-1] ^ opB[WIDTH-1]) && (opB != {WIDTH{1'b0}});
                    negr_d  = opA[WIDTH-1];
                    state_d = S_DIV;
`ifdef MULTDIV_DIVZERO_EN
                    if (opB == {WIDTH{1'b0}}) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_DIV;
                    end
`endif
                end else if (multOp) begin
                    cnt_d   = {CW{1'b0}};
                    acc_d   = {(WIDTH+1){1'b0}};
                    qr_d    = opB;
                    m_d     = opA;
                    q1_d    = 1'b0;
                    state_d = S_MULT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT: begin
                if (cnt_q == CNT_LAST) begin
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = qr_q;
                    state_d = S_DONE;
                end else begin
                    case ({qr_q[0], q1_q})
                        2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
                        2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
                        default: booth_sum = acc_q;
                    endcase
                    {acc_d, qr_d, q1_d} = {booth_sum[WIDTH], booth_sum, qr_q};
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DIV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    if (!rem_diff[WIDTH]) begin
                        acc_d = rem_diff;
                        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh;
                        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FIX: begin
                hi_d    = negr_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                lo_d    = negq_q ? neg_w(qr_q) : qr_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_MULT) || (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
        hilo_d = done_d && !dz_d;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {(WIDTH+1){1'b0}};
            qr_q    <= {WIDTH{1'b0}};
            m_q     <= {WIDTH{1'b0}};
            q1_q    <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hilo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hilo_q  <= hilo_d;
        end
    end

`ifdef MULTDIV_DIVZERO_EN
    logic dz_q;

    // Divide-by-zero flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign divZero = dz_q;
`else
    assign divZero = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign hiLoWrite = hilo_q;
    assign hiOut     = hi_q;
    assign loOut     = lo_q;

endmodule
